// File: rtl/scr1_accel_pkg.sv
// Definitions shared by the byte-multiply accelerator and its job sequencer:
// register map, CTRL bit positions and the sequencer state encoding.
package scr1_accel_pkg;

`include "scr1_memif.svh"

    localparam logic [7:0] ACCEL_CTRL_OFS = 8'h00;
    localparam logic [7:0] ACCEL_A_OFS    = 8'h08;
    localparam logic [7:0] ACCEL_B_OFS    = 8'h0C;
    localparam logic [7:0] ACCEL_C_OFS    = 8'h10;

    localparam int ACCEL_DONE_BIT = 31;
    localparam int ACCEL_GO_BIT   = 0;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_WR_A,
        SEQ_WR_B,
        SEQ_WR_GO,
        SEQ_POLL,
        SEQ_RD_C,
        SEQ_DONE
    } type_scr1_accel_seq_state_e;

endpackage

// File: rtl/scr1_accel_seq_if.sv
// SCR1 dmem bus bundle: the sequencer is the master, the accelerator the slave.
interface scr1_accel_seq_if;
    import scr1_accel_pkg::*;

    logic                          dmem_req;
    logic                          dmem_req_ack;
    type_scr1_mem_cmd_e            dmem_cmd;
    type_scr1_mem_width_e          dmem_width;
    logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr;
    logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata;
    logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata;
    type_scr1_mem_resp_e           dmem_resp;

    modport master (
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/scr1_accel_seq_dmem_if.sv
// Single-access dmem engine: REQ phase until ack, WAIT phase until a response.
// cmd/addr/wdata pass straight through, so the caller must hold them while start is high.
module scr1_accel_seq_dmem_if
    import scr1_accel_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  type_scr1_mem_cmd_e          cmd,
    input  logic [SCR1_DMEM_AWIDTH-1:0] addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] wdata,
    output logic                        done,
    output logic                        err,
    output logic [SCR1_DMEM_DWIDTH-1:0] rdata,
    scr1_accel_seq_if.master            dmem
);

    typedef enum logic {
        PH_REQ,
        PH_WAIT
    } phase_e;

    phase_e phase_q;
    phase_e phase_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_REQ;
        end else begin
            phase_q <= phase_d;
        end
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        phase_d       = phase_q;
        dmem.dmem_req = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (phase_q)
            PH_REQ: begin
                dmem.dmem_req = start;
                if (start && dmem.dmem_req_ack) begin
                    phase_d = PH_WAIT;
                end
            end
            PH_WAIT: begin
                if (dmem.dmem_resp != SCR1_MEM_RESP_NOTRDY) begin
                    done    = 1'b1;
                    err     = (dmem.dmem_resp == SCR1_MEM_RESP_RDY_ER);
                    phase_d = PH_REQ;
                end
            end
            default: phase_d = PH_REQ;
        endcase
    end

    assign dmem.dmem_cmd   = cmd;
    assign dmem.dmem_width = SCR1_MEM_WIDTH_WORD;
    assign dmem.dmem_addr  = addr;
    assign dmem.dmem_wdata = wdata;
    assign rdata           = dmem.dmem_rdata;

endmodule

// File: rtl/scr1_memif.svh
// SCR1 data-memory interface types shared by every dmem master and slave.
// Included inside a package so the types get a single home.
`ifndef SCR1_MEMIF_SVH
`define SCR1_MEMIF_SVH

localparam int SCR1_DMEM_AWIDTH = 32;
localparam int SCR1_DMEM_DWIDTH = 32;

typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

`endif

// File: rtl/scr1_accel_seq.sv
// Job sequencer: takes (A, B), drives the accelerator over dmem (write A, B, GO,
// poll DONE, read C) and offers C, or an error flag, on the result port.
module scr1_accel_seq
    import scr1_accel_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned                 POLL_MAX  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [31:0]         job_a,
    input  logic [31:0]         job_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_c,
    output logic                res_err,
    output logic                busy,
    scr1_accel_seq_if.master    dmem
);

    localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

    type_scr1_accel_seq_state_e state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic        err_q, err_d;
    logic [7:0]  poll_q, poll_d;

    logic                        acc_start;
    type_scr1_mem_cmd_e          acc_cmd;
    logic [7:0]                  acc_ofs;
    logic [SCR1_DMEM_DWIDTH-1:0] acc_wdata;
    logic                        acc_done;
    logic                        acc_err;
    logic [SCR1_DMEM_DWIDTH-1:0] acc_rdata;

    scr1_accel_seq_dmem_if u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .start (acc_start),
        .cmd   (acc_cmd),
        .addr  (BASE_ADDR + SCR1_DMEM_AWIDTH'(acc_ofs)),
        .wdata (acc_wdata),
        .done  (acc_done),
        .err   (acc_err),
        .rdata (acc_rdata),
        .dmem  (dmem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
        end
    end

    // Access target is a pure function of state, which keeps the bus stable through ack stalls.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        err_d     = err_q;
        poll_d    = poll_q;
        acc_start = 1'b0;
        acc_cmd   = SCR1_MEM_CMD_RD;
        acc_ofs   = ACCEL_CTRL_OFS;
        acc_wdata = '0;
        case (state_q)
            SEQ_IDLE: begin
                if (job_valid) begin
                    a_d     = job_a;
                    b_d     = job_b;
                    c_d     = '0;
                    err_d   = 1'b0;
                    poll_d  = '0;
                    state_d = SEQ_WR_A;
                end
            end
            SEQ_WR_A: begin
                acc_start = 1'b1;
                acc_cmd   = SCR1_MEM_CMD_WR;
                acc_ofs   = ACCEL_A_OFS;
                acc_wdata = a_q;
                if (acc_done) state_d = SEQ_WR_B;
            end
            SEQ_WR_B: begin
                acc_start = 1'b1;
                acc_cmd   = SCR1_MEM_CMD_WR;
                acc_ofs   = ACCEL_B_OFS;
                acc_wdata = b_q;
                if (acc_done) state_d = SEQ_WR_GO;
            end
            SEQ_WR_GO: begin
                acc_start               = 1'b1;
                acc_cmd                 = SCR1_MEM_CMD_WR;
                acc_ofs                 = ACCEL_CTRL_OFS;
                acc_wdata[ACCEL_GO_BIT] = 1'b1;
                if (acc_done) state_d = SEQ_POLL;
            end
            SEQ_POLL: begin
                acc_start = 1'b1;
                if (acc_done) begin
                    if (acc_rdata[ACCEL_DONE_BIT]) begin
                        state_d = SEQ_RD_C;
                    end else if (poll_q + 8'd1 == POLL_LIMIT) begin
                        state_d = SEQ_DONE;
                        err_d   = 1'b1;
                        c_d     = '0;
                    end else begin
                        poll_d = poll_q + 8'd1;
                    end
                end
            end
            SEQ_RD_C: begin
                acc_start = 1'b1;
                acc_ofs   = ACCEL_C_OFS;
                if (acc_done) begin
                    c_d     = acc_rdata;
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                if (res_ready) state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase

        // A bus error aborts the job from whichever access raised it.
        if (acc_done && acc_err) begin
            state_d = SEQ_DONE;
            err_d   = 1'b1;
            c_d     = '0;
        end
    end

    assign job_ready = (state_q == SEQ_IDLE);
    assign busy      = (state_q != SEQ_IDLE);
    assign res_valid = (state_q == SEQ_DONE);
    assign res_c     = c_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_scr1_accel_seq.sv
// Scoreboard bench for scr1_accel_seq against a negedge-driven accelerator model
// with configurable ack stalls, error injection and DONE latency.
module tb_scr1_accel_seq;
    import scr1_accel_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_a;
    logic [31:0] job_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_c;
    logic        res_err;
    logic        busy;

    scr1_accel_seq_if dmem_bus ();

    scr1_accel_seq #(
        .BASE_ADDR (32'h0),
        .POLL_MAX  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_a     (job_a),
        .job_b     (job_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_c     (res_c),
        .res_err   (res_err),
        .busy      (busy),
        .dmem      (dmem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected results {err, c}, pushed by stimulus and popped by the monitor.
    logic [32:0] sb_q[$];
    // Accepted bus accesses {wr, addr, wdata}; reads record wdata as 0.
    logic [64:0] log_q[$];
    logic [64:0] exp_log[$];

    int          cfg_stall;
    int          cfg_done_after;
    bit          cfg_err_en;
    logic [31:0] cfg_err_addr;

    function automatic logic [31:0] byte_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] * b[8*i +: 8];
        return r;
    endfunction

    // Accelerator model: decides ack and drives resp on the falling edge.
    initial begin
        logic               pend;
        logic               p_wr;
        logic [31:0]        p_addr;
        logic [31:0]        p_wdata;
        logic               h_cmd;
        logic [31:0]        h_addr;
        logic [31:0]        h_wdata;
        logic [31:0]        reg_a;
        logic [31:0]        reg_b;
        logic               go;
        int                 polls;
        int                 stall_cnt;
        pend = 1'b0; go = 1'b0; polls = 0; stall_cnt = 0;
        reg_a = '0; reg_b = '0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
        h_cmd = 1'b0; h_addr = '0; h_wdata = '0;
        dmem_bus.dmem_req_ack = 1'b0;
        dmem_bus.dmem_resp    = SCR1_MEM_RESP_NOTRDY;
        dmem_bus.dmem_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("req_during_reset", 96'(dmem_bus.dmem_req), 96'(0));
                pend = 1'b0; stall_cnt = 0; go = 1'b0;
                dmem_bus.dmem_req_ack = 1'b0;
                dmem_bus.dmem_resp    = SCR1_MEM_RESP_NOTRDY;
                dmem_bus.dmem_rdata   = '0;
            end else begin
                dmem_bus.dmem_resp  = SCR1_MEM_RESP_NOTRDY;
                dmem_bus.dmem_rdata = '0;
                if (pend) begin
                    pend = 1'b0;
                    if (cfg_err_en && p_addr == cfg_err_addr) begin
                        dmem_bus.dmem_resp = SCR1_MEM_RESP_RDY_ER;
                    end else begin
                        dmem_bus.dmem_resp = SCR1_MEM_RESP_RDY_OK;
                        if (p_wr) begin
                            case (p_addr)
                                32'h08: reg_a = p_wdata;
                                32'h0C: reg_b = p_wdata;
                                32'h00: if (p_wdata[0]) begin go = 1'b1; polls = 0; end
                                default: ;
                            endcase
                        end else begin
                            case (p_addr)
                                32'h00: begin
                                    polls++;
                                    dmem_bus.dmem_rdata[31] = go && cfg_done_after >= 0 && polls > cfg_done_after;
                                end
                                32'h10: dmem_bus.dmem_rdata = byte_mul(reg_a, reg_b);
                                default: ;
                            endcase
                        end
                    end
                end
                dmem_bus.dmem_req_ack = 1'b0;
                if (dmem_bus.dmem_req) begin
                    if (stall_cnt == 0) begin
                        h_cmd   = dmem_bus.dmem_cmd;
                        h_addr  = dmem_bus.dmem_addr;
                        h_wdata = dmem_bus.dmem_wdata;
                    end else begin
                        check("stall_addr_wdata", {dmem_bus.dmem_addr, dmem_bus.dmem_wdata}, {h_addr, h_wdata});
                        check("stall_cmd", 96'(dmem_bus.dmem_cmd), 96'(h_cmd));
                    end
                    if (stall_cnt >= cfg_stall) begin
                        check("dmem_width", 96'(dmem_bus.dmem_width), 96'(SCR1_MEM_WIDTH_WORD));
                        dmem_bus.dmem_req_ack = 1'b1;
                        pend    = 1'b1;
                        p_wr    = (dmem_bus.dmem_cmd == SCR1_MEM_CMD_WR);
                        p_addr  = dmem_bus.dmem_addr;
                        p_wdata = p_wr ? dmem_bus.dmem_wdata : 32'h0;
                        log_q.push_back({p_wr, p_addr, p_wdata});
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
        end
    end

    // Result monitor: compares each handshaked result with the scoreboard head.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 96'(1), 96'(0));
                end else begin
                    exp = sb_q.pop_front();
                    check("res_c", 96'(res_c), 96'(exp[31:0]));
                    check("res_err", 96'(res_err), 96'(exp[32]));
                end
            end
        end
    end

    task automatic send_job(input logic [31:0] a, input logic [31:0] b, input bit push, input logic [32:0] exp);
        bit taken;
        taken = 1'b0;
        if (push) sb_q.push_back(exp);
        job_a = a; job_b = b; job_valid = 1'b1;
        for (int i = 0; i < 400 && !taken; i++) begin
            if (job_ready) taken = 1'b1;
            @(negedge clk);
        end
        job_valid = 1'b0;
        if (!taken) check("job_accept_timeout", 96'(0), 96'(1));
    endtask

    task automatic wait_results();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("result_timeout", 96'(sb_q.size()), 96'(0));
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic exp_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        exp_log.push_back({wr, addr, wdata});
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_log_len"}, 96'(log_q.size()), 96'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            check({tag, "_log_entry"}, 96'(log_q[i]), 96'(exp_log[i]));
    endtask

    task automatic start_test(input int stall, input int done_after, input bit err_en, input logic [31:0] err_addr);
        cfg_stall = stall; cfg_done_after = done_after;
        cfg_err_en = err_en; cfg_err_addr = err_addr;
        log_q.delete(); exp_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_a = '0; job_b = '0; res_ready = 1'b1;
        start_test(0, 0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_job_ready", 96'(job_ready), 96'(1));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_res_valid", 96'(res_valid), 96'(0));
        check("rst_res_err", 96'(res_err), 96'(0));
        check("rst_res_c", 96'(res_c), 96'(0));
        check("rst_dmem_req", 96'(dmem_bus.dmem_req), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait slave, DONE on the third CTRL read.
        start_test(0, 2, 1'b0, 32'h0);
        send_job(32'h04030201, 32'h02020202, 1'b1, {1'b0, 32'h08060402});
        check("busy_in_job", 96'(busy), 96'(1));
        wait_results();
        exp_acc(1, 32'h08, 32'h04030201); exp_acc(1, 32'h0C, 32'h02020202); exp_acc(1, 32'h00, 32'h1);
        exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h10, 0);
        compare_log("zero_wait");

        // Every request stalled three cycles before ack.
        start_test(3, 1, 1'b0, 32'h0);
        send_job(32'h04030201, 32'h02020202, 1'b1, {1'b0, 32'h08060402});
        wait_results();
        exp_acc(1, 32'h08, 32'h04030201); exp_acc(1, 32'h0C, 32'h02020202); exp_acc(1, 32'h00, 32'h1);
        exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h10, 0);
        compare_log("stall3");

        // Error response on the B write: no GO, error result.
        start_test(0, 0, 1'b1, 32'h0C);
        send_job(32'h11223344, 32'h55667788, 1'b1, {1'b1, 32'h0});
        wait_results();
        exp_acc(1, 32'h08, 32'h11223344); exp_acc(1, 32'h0C, 32'h55667788);
        compare_log("err_wr_b");

        // DONE never set: exactly four CTRL reads, then timeout error.
        start_test(0, -1, 1'b0, 32'h0);
        send_job(32'h01010101, 32'h01010101, 1'b1, {1'b1, 32'h0});
        wait_results();
        exp_acc(1, 32'h08, 32'h01010101); exp_acc(1, 32'h0C, 32'h01010101); exp_acc(1, 32'h00, 32'h1);
        exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0);
        compare_log("poll_timeout");

        // Result back-pressure with a second job waiting.
        start_test(0, 0, 1'b0, 32'h0);
        res_ready = 1'b0;
        send_job(32'h04030201, 32'h02020202, 1'b1, {1'b0, 32'h08060402});
        for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
        check("bp_res_valid", 96'(res_valid), 96'(1));
        job_a = 32'hFFFFFFFF; job_b = 32'h01010101; job_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_res_c_stable", 96'(res_c), 96'(32'h08060402));
            check("bp_res_valid_held", 96'(res_valid), 96'(1));
            check("bp_job_ready_low", 96'(job_ready), 96'(0));
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        send_job(32'hFFFFFFFF, 32'h01010101, 1'b1, {1'b0, 32'hFFFFFFFF});
        wait_results();
        check("bp_log_len", 96'(log_q.size()), 96'(10));

        // Reset while a CTRL read request is stalled on the bus.
        start_test(2, -1, 1'b0, 32'h0);
        send_job(32'h04030201, 32'h02020202, 1'b0, 33'h0);
        for (int i = 0; i < 200 && !(log_q.size() >= 4 && dmem_bus.dmem_req); i++) @(negedge clk);
        check("rst_mid_poll_req_seen", 96'(dmem_bus.dmem_req), 96'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_dmem_req", 96'(dmem_bus.dmem_req), 96'(0));
        check("rst_mid_job_ready", 96'(job_ready), 96'(1));
        check("rst_mid_busy", 96'(busy), 96'(0));
        check("rst_mid_res_valid", 96'(res_valid), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_test(0, 1, 1'b0, 32'h0);
        send_job(32'hFFFFFFFF, 32'h01010101, 1'b1, {1'b0, 32'hFFFFFFFF});
        wait_results();
        exp_acc(1, 32'h08, 32'hFFFFFFFF); exp_acc(1, 32'h0C, 32'h01010101); exp_acc(1, 32'h00, 32'h1);
        exp_acc(0, 32'h00, 0); exp_acc(0, 32'h00, 0); exp_acc(0, 32'h10, 0);
        compare_log("after_reset");

        repeat (3) @(negedge clk);
        check("final_idle", 96'(job_ready), 96'(1));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scr1_accel_seq.md
Name: scr1_accel_seq

Overview:
- Hardware job sequencer that drives the byte-multiply accelerator through its dmem slave port, so software or a DMA only pushes operand pairs and pops results.
- Accepts a job (A, B) on a valid/ready port, then as dmem master: writes A, writes B, writes GO, polls DONE, reads C, and presents C on a result valid/ready port.
- Sits between a job source and the accelerator's dmem port, using the same SCR1 dmem master protocol as the core.

Parameters:
- BASE_ADDR, 32'h0, accelerator base address; register offsets are CTRL 0x00 (bit0 go, bit31 done), A 0x08, B 0x0C, C 0x10.
- POLL_MAX, 16, maximum CTRL reads before timeout; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  sequencer idle, job can be taken
- job_a  in  32  operand A
- job_b  in  32  operand B
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_c  out  32  result C (0 on error)
- res_err  out  1  qualifies res_c: dmem ERR response or poll timeout
- busy  out  1  state != IDLE
- dmem_req  out  1  master request
- dmem_req_ack  in  1  slave accepts request this cycle
- dmem_cmd  out  type_scr1_mem_cmd_e  RD/WR
- dmem_width  out  type_scr1_mem_width_e  always WORD
- dmem_addr  out  SCR1_DMEM_AWIDTH  BASE_ADDR + offset
- dmem_wdata  out  SCR1_DMEM_DWIDTH  write data
- dmem_rdata  in  SCR1_DMEM_DWIDTH  read data, valid with RDY_OK
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- Reset is asynchronous: state IDLE, dmem_req 0, res_valid 0, res_err 0, res_c 0, poll count 0, job_ready 1, busy 0. Reset mid-job abandons the job and issues no further dmem traffic.
- States: IDLE, WR_A, WR_B, WR_GO, POLL, RD_C, DONE.
- job_ready = (state == IDLE). When job_valid & job_ready, latch A and B and go to WR_A.
- Each access state has two phases:
  - REQ phase: dmem_req = 1 with cmd, addr and wdata stable until the cycle where dmem_req_ack = 1.
  - WAIT phase: dmem_req = 0 until dmem_resp != NOTRDY.
  - Only one access is outstanding at a time.
  - With a zero-wait slave (ack in the same cycle, resp the next cycle), each access takes 2 cycles.
- Accesses per state:
  - WR_A writes A to 0x08.
  - WR_B writes B to 0x0C.
  - WR_GO writes 32'h1 to 0x00.
  - POLL reads 0x00. If rdata[31] = 1, go to RD_C. Otherwise increment the poll count and reissue the read next cycle. When the poll count reaches POLL_MAX with done still 0, go to DONE with res_err = 1 and res_c = 0.
  - RD_C reads 0x10 and latches rdata into res_c.
- Any dmem_resp = RDY_ER in any state goes straight to DONE with res_err = 1, res_c = 0.
- The poll count clears on entry to WR_A.
- DONE: res_valid = 1; res_c and res_err stay stable until res_valid & res_ready, then return to IDLE. Back-to-back jobs therefore have at least one IDLE cycle between them.
- res_ready is ignored outside DONE. A job_valid arriving in DONE waits.
- dmem_width is always WORD; addresses are word aligned.

Decomposition:
- Share scr1_accel_pkg between this block and the accelerator. It holds:
  - register offsets: ACCEL_CTRL_OFS, ACCEL_A_OFS, ACCEL_B_OFS, ACCEL_C_OFS;
  - the DONE bit index (31) and GO bit index (0);
  - the state enum type_scr1_accel_seq_state_e.
- Memory types come from scr1_memif.svh.
- One sub-module, scr1_accel_seq_dmem_if: the REQ/WAIT single-access engine. Inputs are start, cmd, addr and wdata; outputs are done, err and rdata. The FSM in this block sequences it.

Test Plan:
- Zero-wait accelerator model, A = 32'h04030201, B = 32'h02020202 → write sequence 0x08, 0x0C, 0x00 (wdata 1); CTRL polled until bit31 = 1; read 0x10; res_c = 32'h08060402, res_err = 0.
- Slave delays req_ack by 3 cycles on every access → dmem_req, addr and wdata stay stable through the stall; same result 32'h08060402.
- Slave returns RDY_ER on the WR_B write → no GO write is issued; res_valid with res_err = 1, res_c = 0.
- DONE never set, POLL_MAX = 4 → exactly 4 CTRL reads, then res_err = 1, res_c = 0; no read of 0x10.
- res_ready held low 10 cycles with a second job_valid pending → res_c stable; job_ready = 0 until the handshake; second job (A = 32'hFFFFFFFF, B = 32'h01010101) then yields 32'hFFFFFFFF.
- rst_n asserted during POLL → dmem_req = 0 and state IDLE immediately; the next job completes normally.
